// File: rtl/ascon_lin_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ascon_lin_seq : Ascon linear-layer sequencer driving the rv32 ISE rotate unit
// Revision 1.0
// ---------------------------------------------------------------------------
module ascon_lin_seq #(
  parameter int NUM_ROT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_xl,
  input  logic [31:0] req_xh,
  input  logic [5:0]  req_r0,
  input  logic [5:0]  req_r1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_yl,
  output logic [31:0] rsp_yh,
  output logic [31:0] ise_rs1,
  output logic [31:0] ise_rs2,
  output logic [4:0]  ise_imm,
  output logic        ise_op_rori_l,
  output logic        ise_op_rori_h,
  output logic        ise_op_iornot,
  output logic        ise_op_andnot,
  input  logic [31:0] ise_rd,
  output logic        busy
);

  localparam bit ONE_ROT = (NUM_ROT == 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    R0L  = 3'd1,
    R0H  = 3'd2,
    R1L  = 3'd3,
    R1H  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] x_l, x_h, acc_l, acc_h;
  logic [5:0]  r0, r1;
  logic [5:0]  step_r;
  logic        step_active;

  // Amounts >= 32 are realised by swapping halves; the residual shift is r[4:0].
  always_comb begin
    step_active   = (state == R0L) || (state == R0H) || (state == R1L) || (state == R1H);
    step_r        = ((state == R0L) || (state == R0H)) ? r0 : r1;
    ise_rs1       = '0;
    ise_rs2       = '0;
    ise_imm       = '0;
    ise_op_rori_l = (state == R0L) || (state == R1L);
    ise_op_rori_h = (state == R0H) || (state == R1H);
    if (step_active) begin
      ise_rs1 = step_r[5] ? x_h : x_l;
      ise_rs2 = step_r[5] ? x_l : x_h;
      ise_imm = step_r[4:0];
    end
  end

  assign ise_op_iornot = 1'b0;
  assign ise_op_andnot = 1'b0;
  assign rsp_yl        = rsp_valid ? acc_l : '0;
  assign rsp_yh        = rsp_valid ? acc_h : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x_l       <= '0;
      x_h       <= '0;
      acc_l     <= '0;
      acc_h     <= '0;
      r0        <= '0;
      r1        <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            x_l       <= req_xl;
            x_h       <= req_xh;
            acc_l     <= req_xl;
            acc_h     <= req_xh;
            r0        <= req_r0;
            r1        <= req_r1;
            state     <= R0L;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        R0L: begin
          acc_l <= acc_l ^ ise_rd;
          state <= R0H;
        end
        R0H: begin
          acc_h <= acc_h ^ ise_rd;
          if (ONE_ROT) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
          end else begin
            state <= R1L;
          end
        end
        R1L: begin
          acc_l <= acc_l ^ ise_rd;
          state <= R1H;
        end
        R1H: begin
          acc_h     <= acc_h ^ ise_rd;
          state     <= DONE;
          rsp_valid <= 1'b1;
        end
        DONE: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ascon_lin_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ascon_lin_seq : scoreboard bench for ascon_lin_seq with a behavioural ISE
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_ascon_lin_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_xl, req_xh;
  logic [5:0]  req_r0, req_r1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_yl, rsp_yh;
  logic [31:0] ise_rs1, ise_rs2;
  logic [4:0]  ise_imm;
  logic        ise_op_rori_l, ise_op_rori_h, ise_op_iornot, ise_op_andnot;
  logic [31:0] ise_rd;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;
  logic [63:0] sb[$];

  ascon_lin_seq #(.NUM_ROT(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_xl(req_xl), .req_xh(req_xh), .req_r0(req_r0), .req_r1(req_r1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_yl(rsp_yl), .rsp_yh(rsp_yh),
    .ise_rs1(ise_rs1), .ise_rs2(ise_rs2), .ise_imm(ise_imm),
    .ise_op_rori_l(ise_op_rori_l), .ise_op_rori_h(ise_op_rori_h),
    .ise_op_iornot(ise_op_iornot), .ise_op_andnot(ise_op_andnot),
    .ise_rd(ise_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ISE: rotate {rs2,rs1} right by imm, return the selected half.
  logic [127:0] dbl;
  assign dbl    = {ise_rs2, ise_rs1, ise_rs2, ise_rs1} >> ise_imm;
  assign ise_rd = ise_op_rori_l ? dbl[31:0] : (ise_op_rori_h ? dbl[63:32] : 32'd0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_rsp: got %h required none", {rsp_yh, rsp_yl});
      end else if (rsp_ready) begin
        chk("rsp_y", {rsp_yh, rsp_yl}, sb.pop_front());
      end
    end
  end

  task automatic send(input logic [63:0] x, input logic [5:0] a, input logic [5:0] b,
                      input logic push, input logic [63:0] y);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_xl = x[31:0];
    req_xh = x[63:32];
    req_r0 = a;
    req_r1 = b;
    if (push) sb.push_back(y);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_xl = 32'hDEADBEEF;
    req_xh = 32'hCAFEF00D;
    req_r0 = 6'd7;
    req_r1 = 6'd9;
  endtask

  // Counts edges from the first cycle after accept until rsp_valid.
  task automatic wait_rsp(input int exp_edges);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'(exp_edges));
  endtask

  task automatic run_vec(input logic [63:0] x, input logic [5:0] a, input logic [5:0] b,
                         input logic [63:0] y);
    send(x, a, b, 1'b1, y);
    wait_rsp(4);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_xl = '0; req_xh = '0; req_r0 = '0; req_r1 = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {61'd0, req_ready, rsp_valid, busy}, 64'b100);
    chk("reset_ise", {ise_rs1, ise_rs2}, 64'd0);
    chk("reset_ops", {55'd0, ise_imm, ise_op_rori_l, ise_op_rori_h, ise_op_iornot, ise_op_andnot}, 64'd0);
    chk("reset_y", {rsp_yh, rsp_yl}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_vec(64'h00000000_00000001, 6'd1,  6'd63, 64'h80000000_00000003);
    run_vec(64'hAAAAAAAA_55555555, 6'd32, 6'd0,  64'h55555555_AAAAAAAA);
    run_vec(64'h01234567_89ABCDEF, 6'd19, 6'd19, 64'h01234567_89ABCDEF);
    run_vec(64'hFFFFFFFF_FFFFFFFF, 6'd5,  6'd40, 64'hFFFFFFFF_FFFFFFFF);
    run_vec(64'h00000001_00000000, 6'd36, 6'd33, 64'h90000001_00000000);

    // Operand drive for an amount above 32, checked in R0L then R0H.
    send(64'h00000000_00000100, 6'd40, 6'd8, 1'b1, 64'h00000001_00000101);
    chk("r0l_rs1", 64'(ise_rs1), 64'h0);
    chk("r0l_rs2", 64'(ise_rs2), 64'h100);
    chk("r0l_imm", 64'(ise_imm), 64'd8);
    chk("r0l_ops", {60'd0, ise_op_rori_l, ise_op_rori_h, ise_op_iornot, ise_op_andnot}, 64'b1000);
    @(posedge clk); #1;
    chk("r0h_ops", {60'd0, ise_op_rori_l, ise_op_rori_h, ise_op_iornot, ise_op_andnot}, 64'b0100);
    wait_rsp(3);
    @(posedge clk); #1;

    // Backpressure in DONE.
    rsp_ready = 1'b0;
    send(64'h80000000_00000000, 6'd63, 6'd1, 1'b1, 64'hC0000000_00000001);
    wait_rsp(4);
    for (int i = 0; i < 10; i++) begin
      chk("hold_y", {rsp_yh, rsp_yl}, 64'hC0000000_00000001);
      chk("hold_ctrl", {61'd0, req_ready, rsp_valid, busy}, 64'b011);
      @(posedge clk); #1;
    end
    chk("done_ops", {62'd0, ise_op_rori_l, ise_op_rori_h}, 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_ready", 64'(req_ready), 64'd1);

    // Abort during R1L.
    send(64'h12345678_9ABCDEF0, 6'd3, 6'd50, 1'b0, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("r1l_ops", {60'd0, ise_op_rori_l, ise_op_rori_h, ise_op_iornot, ise_op_andnot}, 64'b1000);
    chk("r1l_rs1", 64'(ise_rs1), 64'h12345678);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ctrl", {61'd0, req_ready, rsp_valid, busy}, 64'b100);
    chk("abort_ise", {ise_rs1, ise_rs2}, 64'd0);
    chk("abort_y", {rsp_yh, rsp_yl}, 64'd0);
    repeat (8) @(posedge clk);
    #1;

    run_vec(64'h00000000_00000001, 6'd32, 6'd0, 64'h00000001_00000000);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
